// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;
  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched instructions; flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output fq_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  fq_entry_t       mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// PC owner and sequential fetcher feeding decode through a small queue.
// FETCH_QUEUE_BYPASS_EN: forward a response straight to decode when the queue is empty.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_data,
  output logic          fq_valid,
  input  logic          fq_ready,
  output logic [31:0]   fq_inst,
  output logic [31:0]   fq_pc,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt_req,
  output logic          halted,
  output logic [CW-1:0] fq_count
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            pending_reg, pending_next;
  logic [XLEN-1:0] pending_pc_reg, pending_pc_next;
  logic            halted_reg, halted_next;

  logic            redirect_act;
  logic            rsp_valid;
  logic            bypass_hit;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  fq_entry_t       fifo_head;
  fq_entry_t       rsp_entry;

  assign redirect_act = redirect_valid && (state_reg != HALTED);
  assign rsp_valid    = pending_reg && !redirect_act;
  assign rsp_entry    = '{pc: pending_pc_reg, inst: imem_data};

  // Occupancy is conservative: the in-flight response already owns a slot.
  assign imem_req  = (state_reg == RUN) && !redirect_valid && !halt_req &&
                     ((fifo_count + CW'(pending_reg)) < DEPTH_C);
  assign imem_addr = pc_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = fifo_empty && rsp_valid;
  assign fq_valid   = !fifo_empty || bypass_hit;
  assign fq_inst    = fifo_empty ? rsp_entry.inst : fifo_head.inst;
  assign fq_pc      = fifo_empty ? rsp_entry.pc   : fifo_head.pc;
`else
  assign bypass_hit = 1'b0;
  assign fq_valid   = !fifo_empty;
  assign fq_inst    = fifo_head.inst;
  assign fq_pc      = fifo_head.pc;
`endif

  assign fifo_pop  = !fifo_empty && fq_ready && !redirect_act;
  assign fifo_push = rsp_valid && !(bypass_hit && fq_ready);
  assign fq_count  = fifo_count;
  assign halted    = halted_reg;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst_b),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .flush     (redirect_act),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pending_next    = imem_req;
    pending_pc_next = pending_pc_reg;

    if (redirect_act) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (imem_req) begin
      pc_next         = pc_reg + XLEN'(INST_BYTES);
      pending_pc_next = pc_reg;
    end

    case (state_reg)
      RUN:     if (halt_req) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !pending_reg) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase

    halted_next = (state_next == HALTED);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_PC;
      pending_reg    <= 1'b0;
      pending_pc_reg <= '0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pending_reg    <= pending_next;
      pending_pc_reg <= pending_pc_next;
      halted_reg     <= halted_next;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_inst;
  logic [31:0] fq_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic [2:0]  fq_count;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fq_valid       (fq_valid),
    .fq_ready       (fq_ready),
    .fq_inst        (fq_inst),
    .fq_pc          (fq_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .fq_count       (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model: fetch address, one outstanding request, list of queued PCs.
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_q[$];
  int          m_phase;   // 0 fetching, 1 draining, 2 stopped
  logic [31:0] mem_rsp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_b          = 1'b1;
    fq_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    @(negedge clk);
    #1;
    check("rst_addr",   imem_addr,        RPC);
    check("rst_valid",  32'(fq_valid),    32'h0);
    check("rst_count",  32'(fq_count),    32'h0);
    check("rst_halted", 32'(halted),      32'h0);
    check("rst_inst",   fq_inst,          32'h0);
    check("rst_pc",     fq_pc,            32'h0);
    @(negedge clk);
    rst_b     = 1'b0;
    m_pc      = RPC;
    m_pend    = 1'b0;
    m_pend_pc = 32'h0;
    m_q.delete();
    m_phase   = 0;
    mem_rsp   = $urandom;
  endtask

  // One clock cycle: apply memory data, compare outputs, advance model.
  task automatic cycle();
    bit          exp_req;
    bit          byp;
    bit          exp_valid;
    bit          redir;
    logic [31:0] exp_hpc;
    logic [31:0] rsp_n;
    int          n;
    int          np;
    imem_data = mem_rsp;
    #1;
    n         = m_q.size();
    redir     = redirect_valid && (m_phase != 2);
    byp       = BYP && (n == 0) && m_pend && !redir;
    exp_req   = (m_phase == 0) && !redirect_valid && !halt_req && (n + int'(m_pend) < DEPTH);
    exp_valid = (n > 0) || byp;
    exp_hpc   = (n > 0) ? m_q[0] : m_pend_pc;
    check("imem_req",  32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr,     m_pc);
    check("fq_valid",  32'(fq_valid), 32'(exp_valid));
    check("fq_count",  32'(fq_count), 32'(n));
    check("halted",    32'(halted),   32'(m_phase == 2));
    if (exp_valid) begin
      check("fq_pc",   fq_pc,   exp_hpc);
      check("fq_inst", fq_inst, exp_hpc ^ KEY);
    end
    rsp_n = imem_req ? (imem_addr ^ KEY) : $urandom;

    np = m_phase;
    if (m_phase == 0 && halt_req) np = 1;
    else if (m_phase == 1 && n == 0 && !m_pend) np = 2;

    if (redir) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = {redirect_pc[31:2], 2'b00};
      $display("redirect to %h", m_pc);
    end else begin
      if (exp_valid && fq_ready) $display("deliver pc=%h inst=%h", fq_pc, fq_inst);
      if (n > 0 && fq_ready) void'(m_q.pop_front());
      if (m_pend && !(byp && fq_ready)) m_q.push_back(m_pend_pc);
      if (exp_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
      m_pend = exp_req;
    end
    m_phase = np;

    @(posedge clk);
    mem_rsp = rsp_n;
    @(negedge clk);
  endtask

  task automatic random_run(input int cycles, input int halt_odds);
    for (int i = 0; i < cycles; i++) begin
      fq_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      halt_req       = (halt_odds > 0) && ($urandom_range(0, halt_odds - 1) == 0);
      cycle();
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    imem_data = 32'h0;
    mem_rsp   = 32'h0;
    do_reset();

    // Streaming from reset across the 32-bit PC wrap.
    fq_ready = 1'b1;
    repeat (20) cycle();

    // Backpressure fills the queue and stops requests.
    fq_ready = 1'b0;
    repeat (10) cycle();
    check("stall_count", 32'(fq_count), 32'd4);
    check("stall_req",   32'(imem_req), 32'd0);
    fq_ready = 1'b1;
    repeat (20) cycle();

    // Redirect while three queued and one in flight.
    fq_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    cycle();
    redirect_valid = 1'b0;
    repeat (4) cycle();
    check("pre_redir_count", 32'(fq_count), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    check("redir_addr", imem_addr, 32'h0000_0100);
    fq_ready = 1'b1;
    repeat (10) cycle();

    random_run(400, 0);

    // Halt with two queued and one in flight, then try to redirect.
    fq_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    cycle();
    redirect_valid = 1'b0;
    repeat (3) cycle();
    check("pre_halt_count", 32'(fq_count), 32'd2);
    fq_ready = 1'b1;
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    repeat (6) cycle();
    check("halt_done", 32'(halted), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_8000;
    repeat (3) cycle();
    redirect_valid = 1'b0;

    // Random traffic with sporadic halts, restarting from reset.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      random_run(150, 64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

- Upstream neighbour of the core's decode stage: owns the PC, issues sequential word fetches to instruction memory and buffers returned instructions in a small FIFO.
- Hands instructions with their PC to decode over a valid/ready handshake.
- Decode/execute steers fetch through a redirect (branch, jump, JALR target) and a halt request (ECALL/opcode 0x73).

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst_b, input, 1: reset, asynchronous, active-high.
- imem_req, output, 1: fetch request this cycle.
- imem_addr, output, 32: fetch address, word-aligned, equals PC register.
- imem_data, input, 32: instruction returned exactly one cycle after an accepted request.
- fq_valid, output, 1: head entry available.
- fq_ready, input, 1: decode accepts head.
- fq_inst, output, 32: head instruction.
- fq_pc, output, 32: head PC.
- redirect_valid, input, 1: flush and restart fetch.
- redirect_pc, input, 32: new PC; bits [1:0] forced to 0.
- halt_req, input, 1: stop fetching (level or pulse).
- halted, output, 1: fetch stopped and queue drained.
- fq_count, output, $clog2(DEPTH)+1: occupied entries.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- RUN → DRAIN on halt_req. DRAIN → HALTED when count==0 and no response pending. HALTED is terminal until reset.
- Issue rule, evaluated in RUN only: imem_req = !redirect_valid && (count + pending < DEPTH). Occupancy is conservative: a same-cycle pop is not credited.
- On issue, PC ← PC+4 (32-bit wrap: 0xFFFF_FFFC → 0) and pending ← 1.
- Response cycle: the memory word is pushed into the queue with the PC that was issued for it, then pending ← 0.
- Pop: occurs when fq_valid && fq_ready.
- Redirect has priority over all other events:
  - queue emptied; any pending response discarded;
  - PC ← {redirect_pc[31:2],2'b0}; no issue, push or pop in that cycle;
  - a handshake in the redirect cycle is void;
  - in DRAIN the redirect also empties the queue (halt still wins, no refetch);
  - in HALTED the redirect is ignored.
- Simultaneous push and pop: count unchanged, so a full queue can accept a push when popping.
- No push is ever lost. The issue rule guarantees a free slot for every pending response.

## Timing
Reset values:
- imem_addr = RESET_PC; imem_req = 1 in the first cycle after reset release.
- fq_valid = 0; fq_count = 0; halted = 0.
- fq_inst = 0; fq_pc = 0.

Without bypass:
- Request at cycle t, data on imem_data at t+1, fq_valid at t+2.
- Sustained throughput is one instruction per cycle with fq_ready held high.

Redirect at cycle r:
- imem_addr = target at r+1 with imem_req = 1.
- First instruction from the new path at r+3 (r+2 with bypass).

halted:
- Asserts the cycle after the drain condition is met.
- Is registered.

## Configuration
FETCH_QUEUE_BYPASS_EN
- Defined: when the queue is empty, a response arriving at t+1 drives fq_valid/fq_inst/fq_pc combinationally in that same cycle.
  - If fq_ready is high, the response is consumed without being pushed.
  - Otherwise it is pushed as normal.
- Undefined: every response goes through the queue. Outputs come straight from flops, with no combinational imem_data→fq_* path.

## Structure
- Package fetch_pkg holds:
  - XLEN = 32 and INST_BYTES = 4;
  - fetch_state_t enum {RUN, DRAIN, HALTED};
  - fq_entry_t packed struct {pc[31:0], inst[31:0]}.
- One sub-module, fetch_fifo:
  - parameterised DEPTH FIFO of fq_entry_t;
  - push, pop, flush, count;
  - pointers wrap modulo DEPTH;
  - full/empty derived from count.
- Top level holds the PC, pending flag, FSM, issue logic and optional bypass.

## Test plan
- Reset, fq_ready=1, memory returns addr^32'hA5A5_0000 → fq_pc sequence 0,4,8,…; first fq_valid at cycle 2; one per cycle thereafter.
- fq_ready=0 for 10 cycles → imem_req drops after 4 issues, fq_count=4, no lost or duplicated PCs after fq_ready=1.
- redirect_valid with redirect_pc=0x0000_0103 while pending and queue holding 3 → queue flushed, next imem_addr=0x100, next fq_pc=0x100, stale instruction never seen.
- halt_req with 2 queued and 1 pending, fq_ready=1 → 3 more instructions delivered, no new requests, halted=1 one cycle after drain; later redirect ignored.
- RESET_PC=0xFFFF_FFF8 → PCs FFF8, FFFC, 0000 (wrap).
- With FETCH_QUEUE_BYPASS_EN, empty queue, fq_ready=1 → fq_valid in the response cycle (t+1), fq_count stays 0.
